famicom_pad_responder: RTL and testbench

Emulates the Famicom/NES serial game controller that the Gigatron shell polls over `famicom_latch` / `famicom_pulse` / `famicom_data`. It sits in the `emu` top level between `hps_io` (joystick bits and `ps2_key`) and `Gigatron_Shell`. It synchronises the shell's latch and pulse strobes into `clk_sys`, snapshots one byte per latch, and shifts that byte out MSB first, active low. Keyboard presses are injected as ASCII bytes, which the Gigatron ROM accepts on the same input path.

---
 rtl/famicom_pad_responder.sv | 197 +++++++++++++++++++
 tb/tb_famicom_pad_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/famicom_pad_responder.sv
// rtl/famicom_pad_responder.sv - Famicom/NES serial pad emulation with ASCII keyboard injection.
// Latch/pulse strobes are resynchronised into clk_sys; one byte per latch is shifted out MSB first, active low.
module famicom_pad_responder #(
    parameter int HOLD_LATCHES = 3
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [7:0]  joy,
    input  logic [10:0] ps2_key,
    input  logic        famicom_latch,
    input  logic        famicom_pulse,
    output logic        famicom_data,
    output logic [7:0]  snapshot
);

    localparam logic [3:0] HOLD_CNT = 4'(HOLD_LATCHES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // [0],[1] form the synchroniser; [2] is the previous synchronised level for edge detection
    logic [2:0] lat_sync_q;
    logic [2:0] pul_sync_q;
    logic       lat_re;
    logic       pul_re;
    logic       lat_level;

    logic       kb_primed_q, kb_primed_d;
    logic       kb_tog_q,    kb_tog_d;
    logic [7:0] kb_byte_q,   kb_byte_d;
    logic [3:0] kb_cnt_q,    kb_cnt_d;
    logic       key_event;
    logic [8:0] key_map;

    state_t     state_q,   state_d;
    logic [7:0] sh_q,      sh_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       data_q,    data_d;
    logic [7:0] snap_q,    snap_d;
    logic [7:0] snap_sel;

    // Returns {mapped, ascii} for a set-2 make code
    function automatic logic [8:0] map_scancode(input logic [7:0] sc);
        logic [8:0] r;
        r = 9'h000;
        case (sc)
            8'h1C: r = {1'b1, 8'h61}; // a
            8'h32: r = {1'b1, 8'h62};
            8'h21: r = {1'b1, 8'h63};
            8'h23: r = {1'b1, 8'h64};
            8'h24: r = {1'b1, 8'h65};
            8'h2B: r = {1'b1, 8'h66};
            8'h34: r = {1'b1, 8'h67};
            8'h33: r = {1'b1, 8'h68};
            8'h43: r = {1'b1, 8'h69};
            8'h3B: r = {1'b1, 8'h6A};
            8'h42: r = {1'b1, 8'h6B};
            8'h4B: r = {1'b1, 8'h6C};
            8'h3A: r = {1'b1, 8'h6D};
            8'h31: r = {1'b1, 8'h6E};
            8'h44: r = {1'b1, 8'h6F};
            8'h4D: r = {1'b1, 8'h70};
            8'h15: r = {1'b1, 8'h71};
            8'h2D: r = {1'b1, 8'h72};
            8'h1B: r = {1'b1, 8'h73};
            8'h2C: r = {1'b1, 8'h74};
            8'h3C: r = {1'b1, 8'h75};
            8'h2A: r = {1'b1, 8'h76};
            8'h1D: r = {1'b1, 8'h77};
            8'h22: r = {1'b1, 8'h78};
            8'h35: r = {1'b1, 8'h79};
            8'h1A: r = {1'b1, 8'h7A}; // z
            8'h45: r = {1'b1, 8'h30}; // 0
            8'h16: r = {1'b1, 8'h31};
            8'h1E: r = {1'b1, 8'h32};
            8'h26: r = {1'b1, 8'h33};
            8'h25: r = {1'b1, 8'h34};
            8'h2E: r = {1'b1, 8'h35};
            8'h36: r = {1'b1, 8'h36};
            8'h3D: r = {1'b1, 8'h37};
            8'h3E: r = {1'b1, 8'h38};
            8'h46: r = {1'b1, 8'h39}; // 9
            8'h29: r = {1'b1, 8'h20}; // space
            8'h5A: r = {1'b1, 8'h0A}; // enter
            8'h66: r = {1'b1, 8'h7F}; // backspace
            8'h76: r = {1'b1, 8'h1B}; // esc
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            lat_sync_q <= 3'b000;
            pul_sync_q <= 3'b000;
        end else begin
            lat_sync_q <= {lat_sync_q[1:0], famicom_latch};
            pul_sync_q <= {pul_sync_q[1:0], famicom_pulse};
        end
    end

    assign lat_level = lat_sync_q[1];
    assign lat_re    = lat_sync_q[1] & ~lat_sync_q[2];
    assign pul_re    = pul_sync_q[1] & ~pul_sync_q[2];

    // The first cycle out of reset only primes the toggle copy, so a stale toggle level is not a key
    assign key_event = kb_primed_q & (ps2_key[10] != kb_tog_q);
    assign key_map   = map_scancode(ps2_key[7:0]);

    always_comb begin
        kb_primed_d = 1'b1;
        kb_tog_d    = ps2_key[10];
        kb_byte_d   = kb_byte_q;
        kb_cnt_d    = kb_cnt_q;
        if (lat_re && (kb_cnt_q != 4'd0)) begin
            kb_cnt_d = kb_cnt_q - 4'd1;
        end
        // A new key overrides the decrement; the current latch already used the old state
        if (key_event && ps2_key[9] && !ps2_key[8] && key_map[8]) begin
            kb_byte_d = key_map[7:0];
            kb_cnt_d  = HOLD_CNT;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            kb_primed_q <= 1'b0;
            kb_tog_q    <= 1'b0;
            kb_byte_q   <= 8'hFF;
            kb_cnt_q    <= 4'd0;
        end else begin
            kb_primed_q <= kb_primed_d;
            kb_tog_q    <= kb_tog_d;
            kb_byte_q   <= kb_byte_d;
            kb_cnt_q    <= kb_cnt_d;
        end
    end

    assign snap_sel = (kb_cnt_q != 4'd0) ? kb_byte_q : ~joy;

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        snap_d    = snap_q;
        if (lat_re) begin
            snap_d    = snap_sel;
            sh_d      = snap_sel;
            bit_cnt_d = 4'd0;
            data_d    = snap_sel[7];
            state_d   = ST_SHIFT;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (pul_re && !lat_level) begin
                        sh_d      = {sh_q[6:0], 1'b1};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        data_d    = sh_q[6];
                        if (bit_cnt_q == 4'd7) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    data_d = 1'b1;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            sh_q      <= 8'hFF;
            bit_cnt_q <= 4'd0;
            data_q    <= 1'b1;
            snap_q    <= 8'hFF;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            snap_q    <= snap_d;
        end
    end

    assign famicom_data = data_q;
    assign snapshot     = snap_q;

endmodule

// File: tb/tb_famicom_pad_responder.sv
// tb/tb_famicom_pad_responder.sv - directed bench for famicom_pad_responder.
module tb_famicom_pad_responder;

    logic        clk_sys;
    logic        reset_n;
    logic [7:0]  joy;
    logic [10:0] ps2_key;
    logic        famicom_latch;
    logic        famicom_pulse;
    logic        famicom_data;
    logic [7:0]  snapshot;

    int n_checks;
    int n_fail;

    famicom_pad_responder #(.HOLD_LATCHES(3)) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .joy           (joy),
        .ps2_key       (ps2_key),
        .famicom_latch (famicom_latch),
        .famicom_pulse (famicom_pulse),
        .famicom_data  (famicom_data),
        .snapshot      (snapshot)
    );

    initial clk_sys = 1'b0;
    always #10 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic pulse_chk(input string tag, input logic exp_bit);
        famicom_pulse = 1'b1;
        wait_clk(4);
        chk(tag, {7'b0, famicom_data}, {7'b0, exp_bit});
        famicom_pulse = 1'b0;
        wait_clk(4);
    endtask

    task automatic latch_only(input string tag, input logic [7:0] exp);
        famicom_latch = 1'b1;
        wait_clk(4);
        chk({tag, " snap"}, snapshot, exp);
        chk({tag, " b7"}, {7'b0, famicom_data}, {7'b0, exp[7]});
        famicom_latch = 1'b0;
        wait_clk(4);
    endtask

    task automatic frame(input string tag, input logic [7:0] exp);
        latch_only(tag, exp);
        for (int i = 6; i >= 0; i--) begin
            pulse_chk($sformatf("%s b%0d", tag, i), exp[i]);
        end
        pulse_chk({tag, " p8"}, 1'b1);
        pulse_chk({tag, " p9"}, 1'b1);
    endtask

    task automatic key(input logic pressed, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, ext, code};
        wait_clk(3);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset_n       = 1'b0;
        joy           = 8'h00;
        ps2_key       = 11'h000;
        famicom_latch = 1'b0;
        famicom_pulse = 1'b0;
        wait_clk(3);
        chk("reset data", {7'b0, famicom_data}, 8'h01);
        chk("reset snap", snapshot, 8'hFF);
        reset_n = 1'b1;
        wait_clk(3);

        frame("idle", 8'hFF);

        // bit 7 becomes visible exactly three cycles after the latch edge
        joy = 8'b1000_0001;
        famicom_latch = 1'b1;
        wait_clk(2);
        chk("lat 2cyc", {7'b0, famicom_data}, 8'h01);
        wait_clk(1);
        chk("lat 3cyc", {7'b0, famicom_data}, 8'h00);
        famicom_latch = 1'b0;
        wait_clk(4);
        for (int i = 6; i >= 0; i--) begin
            pulse_chk($sformatf("joy b%0d", i), i == 0 ? 1'b0 : 1'b1);
        end
        pulse_chk("joy p9", 1'b1);

        // joy changes after the latch must not alter the byte in flight
        joy = 8'h81;
        famicom_latch = 1'b1;
        wait_clk(4);
        famicom_latch = 1'b0;
        joy = 8'h00;
        wait_clk(4);
        pulse_chk("midjoy b6", 1'b1);
        joy = 8'h81;

        key(1'b1, 1'b0, 8'h1C);
        frame("kb1", 8'h61);
        frame("kb2", 8'h61);
        frame("kb3", 8'h61);
        latch_only("kb4", 8'h7E);

        joy = 8'h10;
        key(1'b0, 1'b0, 8'h1C);
        latch_only("release", 8'hEF);
        key(1'b1, 1'b1, 8'h75);
        latch_only("ext up", 8'hEF);
        key(1'b1, 1'b0, 8'h07);
        latch_only("unmapped", 8'hEF);
        key(1'b1, 1'b0, 8'h5A);
        latch_only("enter", 8'h0A);
        key(1'b1, 1'b0, 8'h46);
        latch_only("digit9", 8'h39);
        latch_only("digit9 h2", 8'h39);
        latch_only("digit9 h3", 8'h39);
        latch_only("after hold", 8'hEF);

        // collide latch and pulse while mid-frame: latch reloads, pulse is dropped
        joy = 8'h81;
        famicom_latch = 1'b1;
        wait_clk(4);
        famicom_latch = 1'b0;
        wait_clk(4);
        pulse_chk("pre col b6", 1'b1);
        pulse_chk("pre col b5", 1'b1);
        famicom_latch = 1'b1;
        famicom_pulse = 1'b1;
        wait_clk(4);
        chk("col b7", {7'b0, famicom_data}, 8'h00);
        famicom_pulse = 1'b0;
        wait_clk(4);
        famicom_pulse = 1'b1;
        wait_clk(4);
        chk("pulse latch high", {7'b0, famicom_data}, 8'h00);
        famicom_pulse = 1'b0;
        wait_clk(4);
        famicom_latch = 1'b0;
        wait_clk(4);
        for (int i = 6; i >= 0; i--) begin
            pulse_chk($sformatf("col b%0d", i), i == 0 ? 1'b0 : 1'b1);
        end
        pulse_chk("col p8", 1'b1);

        // async reset mid-frame with a key pending
        joy = 8'h08;
        famicom_latch = 1'b1;
        wait_clk(4);
        famicom_latch = 1'b0;
        wait_clk(4);
        key(1'b1, 1'b0, 8'h1C);
        for (int i = 6; i >= 4; i--) begin
            pulse_chk($sformatf("rst pre b%0d", i), 1'b1);
        end
        pulse_chk("rst pre b3", 1'b0);
        @(posedge clk_sys);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst async data", {7'b0, famicom_data}, 8'h01);
        chk("rst async snap", snapshot, 8'hFF);
        wait_clk(2);
        reset_n = 1'b1;
        wait_clk(3);
        frame("post rst", 8'hF7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
